// File: rtl/alu_exec.sv
`default_nettype none
// ============================================================================
//  Module   : alu_exec
//  Purpose  : Execute stage fed by the register bank read ports. Single-cycle
//             logic/arithmetic ops, iterative shift-add MUL (one partial
//             product per cycle), registered result/flags and a one-cycle
//             done strobe used as the bank write-back enable.
//  Ports    : Clk, Rst (async, active-high)
//             start, op[2:0], Rx, Ry          -> request and operands
//             busy, done                      -> status / write-back strobe
//             result, result_hi               -> result (MUL: low/high half)
//             flag_z, flag_c, flag_n, flag_v  -> zero/carry/negative/overflow
//  Revision : 1.0  initial release
// ============================================================================
module alu_exec #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] Rx,
  input  logic [WIDTH-1:0] Ry,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_n,
  output logic             flag_v
);

  localparam logic [2:0] C_OP_ADD = 3'b000;
  localparam logic [2:0] C_OP_SUB = 3'b001;
  localparam logic [2:0] C_OP_AND = 3'b010;
  localparam logic [2:0] C_OP_OR  = 3'b011;
  localparam logic [2:0] C_OP_XOR = 3'b100;
  localparam logic [2:0] C_OP_SHL = 3'b101;
  localparam logic [2:0] C_OP_SHR = 3'b110;
  localparam logic [2:0] C_OP_MUL = 3'b111;

  localparam int              CW     = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   C_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_count;

  // Single-cycle datapath
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic [WIDTH:0]     w_shl_ext;
  logic [WIDTH:0]     w_shr_ext;
  logic [WIDTH-1:0]   w_res;
  logic               w_c;
  logic               w_v;

  // Multiplier step
  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH:0]     w_upper;
  logic [2*WIDTH-1:0] w_acc_next;

  assign w_sum  = {1'b0, Rx} + {1'b0, Ry};
  assign w_diff = {1'b0, Rx} - {1'b0, Ry};   // MSB is the borrow
  // One guard bit on the shifted-out side: after shifting it holds the last
  // bit that left the operand, and is 0 for a zero shift amount.
  assign w_shl_ext = {1'b0, Rx} << Ry[2:0];
  assign w_shr_ext = {Rx, 1'b0} >> Ry[2:0];

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (op)
      C_OP_ADD: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (Rx[WIDTH-1] == Ry[WIDTH-1]) && (w_sum[WIDTH-1] != Rx[WIDTH-1]);
      end
      C_OP_SUB: begin
        w_res = w_diff[WIDTH-1:0];
        w_c   = w_diff[WIDTH];
        w_v   = (Rx[WIDTH-1] != Ry[WIDTH-1]) && (w_diff[WIDTH-1] != Rx[WIDTH-1]);
      end
      C_OP_AND: w_res = Rx & Ry;
      C_OP_OR:  w_res = Rx | Ry;
      C_OP_XOR: w_res = Rx ^ Ry;
      C_OP_SHL: begin
        w_res = w_shl_ext[WIDTH-1:0];
        w_c   = w_shl_ext[WIDTH];
      end
      C_OP_SHR: begin
        w_res = w_shr_ext[WIDTH:1];
        w_c   = w_shr_ext[0];
      end
      default: ;
    endcase
  end

  // Shift-add: add into the upper half (keeping the carry), then shift the
  // whole accumulator right one place with the carry entering at the top.
  assign w_addend   = r_mplier[0] ? r_mcand : '0;
  assign w_upper    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
  assign w_acc_next = {w_upper, r_acc[WIDTH-1:1]};

  assign busy = (r_state != ST_IDLE);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state   <= ST_IDLE;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_count   <= '0;
      done      <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      flag_z    <= 1'b0;
      flag_c    <= 1'b0;
      flag_n    <= 1'b0;
      flag_v    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (op == C_OP_MUL) begin
              r_mcand  <= Rx;
              r_mplier <= Ry;
              r_acc    <= '0;
              r_count  <= '0;
              r_state  <= ST_MUL;
            end else begin
              result    <= w_res;
              result_hi <= '0;
              flag_z    <= (w_res == '0);
              flag_c    <= w_c;
              flag_n    <= w_res[WIDTH-1];
              flag_v    <= w_v;
              done      <= 1'b1;
              r_state   <= ST_DONE;
            end
          end
        end
        ST_MUL: begin
          r_acc    <= w_acc_next;
          r_mplier <= r_mplier >> 1;
          r_count  <= r_count + CW'(1);
          if (r_count == C_LAST) begin
            result    <= w_acc_next[WIDTH-1:0];
            result_hi <= w_acc_next[2*WIDTH-1:WIDTH];
            flag_z    <= (w_acc_next == '0);
            flag_c    <= (w_acc_next[2*WIDTH-1:WIDTH] != '0);
            flag_n    <= w_acc_next[WIDTH-1];
            flag_v    <= 1'b0;
            done      <= 1'b1;
            r_state   <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_exec.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_exec
//  Purpose  : Self-checking bench for alu_exec. An arithmetic reference model
//             tracks expected outputs cycle by cycle; directed vectors add
//             hand-computed literal expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_exec;

  logic       Clk;
  logic       Rst;
  logic       start;
  logic [2:0] op;
  logic [7:0] Rx;
  logic [7:0] Ry;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic [7:0] result_hi;
  logic       flag_z;
  logic       flag_c;
  logic       flag_n;
  logic       flag_v;

  int n_checks = 0;
  int n_err    = 0;

  alu_exec #(.WIDTH(8)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .start     (start),
    .op        (op),
    .Rx        (Rx),
    .Ry        (Ry),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .result_hi (result_hi),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .flag_n    (flag_n),
    .flag_v    (flag_v)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: returns {result, result_hi, z, c, n, v} from plain arithmetic.
  function automatic logic [19:0] model_op(input logic [2:0] o,
                                           input logic [7:0] a,
                                           input logic [7:0] b);
    int ia, ib, sa, sb, s, full, r, hi;
    logic z, c, n, v;
    ia = a; ib = b;
    sa = $signed(a); sb = $signed(b);
    s  = ib % 8;
    r = 0; hi = 0; c = 1'b0; v = 1'b0;
    case (o)
      3'd0: begin
        full = ia + ib; r = full % 256; c = (full > 255);
        v = (sa + sb > 127) || (sa + sb < -128);
      end
      3'd1: begin
        r = (ia - ib + 256) % 256; c = (ia < ib);
        v = (sa - sb > 127) || (sa - sb < -128);
      end
      3'd2: r = ia & ib;
      3'd3: r = ia | ib;
      3'd4: r = ia ^ ib;
      3'd5: begin
        r = (ia << s) % 256;
        c = (s != 0) && (((ia >> (8 - s)) & 1) == 1);
      end
      3'd6: begin
        r = ia >> s;
        c = (s != 0) && (((ia >> (s - 1)) & 1) == 1);
      end
      default: begin
        full = ia * ib; r = full % 256; hi = full / 256; c = (hi != 0);
      end
    endcase
    z = (r == 0) && (hi == 0);
    n = (r >= 128);
    return {8'(r), 8'(hi), z, c, n, v};
  endfunction

  // Behavioural model state: expected outputs, remaining MUL cycles.
  logic [19:0] m_out  = '0;
  logic [19:0] m_pend = '0;
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  int          m_wait = 0;

  always @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      m_out = '0; m_busy = 1'b0; m_done = 1'b0; m_wait = 0;
    end else if (m_done) begin
      m_done = 1'b0;
      m_busy = 1'b0;
    end else if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) begin
        m_out  = m_pend;
        m_done = 1'b1;
      end
    end else if (start) begin
      m_busy = 1'b1;
      if (op == 3'd7) begin
        m_pend = model_op(op, Rx, Ry);
        m_wait = 8;
      end else begin
        m_out  = model_op(op, Rx, Ry);
        m_done = 1'b1;
      end
    end
  end

  // Compare process: outputs are always meaningful (hold rule), so every cycle.
  always @(negedge Clk) begin
    chk("cyc_busy",   int'(busy),      int'(m_busy));
    chk("cyc_done",   int'(done),      int'(m_done));
    chk("cyc_result", int'(result),    int'(m_out[19:12]));
    chk("cyc_hi",     int'(result_hi), int'(m_out[11:4]));
    chk("cyc_flags",  int'({flag_z, flag_c, flag_n, flag_v}), int'(m_out[3:0]));
  end

  // Issue one op, wait for done, check literal expectations.
  task automatic run(input string nm, input logic [2:0] o, input logic [7:0] a,
                     input logic [7:0] b, input logic [7:0] er, input logic [7:0] eh,
                     input logic [3:0] ef, input int ebusy, input bit disturb);
    int nbusy;
    bit got;
    nbusy = 0; got = 1'b0;
    @(negedge Clk); #1;
    start = 1'b1; op = o; Rx = a; Ry = b;
    @(posedge Clk); #1;
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (busy) nbusy++;
      if (done) begin got = 1'b1; break; end
      if (disturb && i == 3) begin #1; start = 1'b1; Rx = ~Rx; Ry = 8'h12; end
      if (disturb && i == 4) begin #1; start = 1'b0; Rx = 8'h00; end
    end
    chk({nm, "_done_seen"}, int'(got), 1);
    chk({nm, "_result"},    int'(result), int'(er));
    chk({nm, "_hi"},        int'(result_hi), int'(eh));
    chk({nm, "_flags_zcnv"}, int'({flag_z, flag_c, flag_n, flag_v}), int'(ef));
    chk({nm, "_busy_cycles"}, nbusy, ebusy);
  endtask

  initial begin
    int ndone;
    Rst = 1'b0; start = 1'b0; op = 3'd0; Rx = 8'h00; Ry = 8'h00;
    #2 Rst = 1'b1;
    repeat (2) @(negedge Clk);
    chk("rst_busy",    int'(busy), 0);
    chk("rst_outputs", int'({done, result, result_hi, flag_z, flag_c, flag_n, flag_v}), 0);
    #1 Rst = 1'b0;
    @(negedge Clk);
    chk("idle_busy", int'(busy), 0);

    //                    op     Rx     Ry     res    hi     zcnv     busy
    run("add_ovf",  3'd0, 8'h7F, 8'h01, 8'h80, 8'h00, 4'b0011, 1, 1'b0);
    run("sub_neg",  3'd1, 8'h05, 8'h07, 8'hFE, 8'h00, 4'b0110, 1, 1'b0);
    run("sub_zero", 3'd1, 8'h33, 8'h33, 8'h00, 8'h00, 4'b1000, 1, 1'b0);
    run("add_carry",3'd0, 8'hFF, 8'h01, 8'h00, 8'h00, 4'b1100, 1, 1'b0);
    run("shl_1",    3'd5, 8'h81, 8'h01, 8'h02, 8'h00, 4'b0100, 1, 1'b0);
    run("shr_0",    3'd6, 8'h81, 8'h00, 8'h81, 8'h00, 4'b0010, 1, 1'b0);
    run("shr_3",    3'd6, 8'h81, 8'h03, 8'h10, 8'h00, 4'b0000, 1, 1'b0);
    run("or",       3'd3, 8'hA0, 8'h05, 8'hA5, 8'h00, 4'b0010, 1, 1'b0);
    run("xor",      3'd4, 8'h5A, 8'h5A, 8'h00, 8'h00, 4'b1000, 1, 1'b0);
    run("mul_ffff", 3'd7, 8'hFF, 8'hFF, 8'h01, 8'hFE, 4'b0100, 9, 1'b1);
    run("mul_zero", 3'd7, 8'h00, 8'h5A, 8'h00, 8'h00, 4'b1000, 9, 1'b0);
    run("mul_10_0f",3'd7, 8'h10, 8'h0F, 8'hF0, 8'h00, 4'b0010, 9, 1'b0);

    // Reset in the middle of a multiply: everything clears, no done follows.
    @(negedge Clk); #1;
    start = 1'b1; op = 3'd7; Rx = 8'h0F; Ry = 8'h0F;
    @(posedge Clk); #1;
    start = 1'b0;
    repeat (4) @(posedge Clk);
    #1 Rst = 1'b1;
    #1;
    chk("midmul_rst_busy",    int'(busy), 0);
    chk("midmul_rst_outputs", int'({done, result, result_hi, flag_z, flag_c, flag_n, flag_v}), 0);
    @(negedge Clk); #1 Rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge Clk);
      if (done) ndone++;
    end
    chk("midmul_no_done", ndone, 0);

    run("and_after_rst", 3'd2, 8'hF0, 8'h3C, 8'h30, 8'h00, 4'b0000, 1, 1'b0);

    repeat (3) @(negedge Clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
